// File: rtl/coproc_host_bridge_if.sv
// Host/coprocessor signal bundle for coproc_host_bridge: request/response handshake
// on the host side plus the 32-bit instruction/result pair toward the controller.
interface coproc_host_bridge_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [3:0]   req_addr;
  logic [255:0] req_wdata;
  logic [31:0]  instr;
  logic [31:0]  coproc_out;
  logic         rsp_valid;
  logic [255:0] rsp_rdata;
  logic         rsp_err;
  logic         busy;

  // bridge side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, coproc_out,
    output req_ready, instr, rsp_valid, rsp_rdata, rsp_err, busy
  );

  // host / harness side
  modport master (
    output req_valid, req_write, req_addr, req_wdata, coproc_out,
    input  req_ready, instr, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/coproc_host_bridge.sv
// Serializes one 256-bit register request into header/data frames on instr and
// gathers read words back. Optional macro HOST_BRIDGE_ADDR_CHECK_EN rejects 1-word regs.
module coproc_host_bridge #(
  parameter logic [3:0] IDLE_ADDR = 4'hF,
  parameter int         READ_LAT  = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  coproc_host_bridge_if.slave  bus
);

  // HDR is folded into IDLE_HDR so the real header goes out on the accept cycle.
  typedef enum logic [3:0] {
    IDLE_HDR, IDLE_BODY, HDR, WDATA, RSLOT, TAIL, COMMIT, DRAIN, RESP
  } state_e;

  function automatic logic [3:0] nwords(input logic [3:0] a);
    case (a)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9: nwords = 4'd4;
      4'd5, 4'd6:                         nwords = 4'd8;
      4'd12, 4'd13, 4'd14:                nwords = 4'd5;
      default:                            nwords = 4'd1;
    endcase
  endfunction

  localparam logic [3:0]  FILL_N   = nwords(IDLE_ADDR);
  localparam logic [31:0] FILL_HDR = {1'b0, IDLE_ADDR, 27'b0};

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        wr_q;
  logic [3:0]                  n_q;
  logic [7:0][31:0]            wdata_q, rdata_q;
  logic                        err_pend_q, done_q;
  logic [READ_LAT:1]           vld_q;
  logic [READ_LAT:1][2:0]      idx_q;
  logic [READ_LAT:0]           vld_pipe;
  logic [READ_LAT:0][2:0]      idx_pipe;
  logic                        accept, bad, cap_last, done;

  assign accept = (state_q == IDLE_HDR) && reset_n && bus.req_valid;

`ifdef HOST_BRIDGE_ADDR_CHECK_EN
  assign bad = (nwords(bus.req_addr) == 4'd1) && (bus.req_addr != IDLE_ADDR);
`else
  assign bad = 1'b0;
`endif

  // Slot index travels alongside its valid bit until the word returns.
  assign vld_pipe = {vld_q, state_q == RSLOT};
  assign idx_pipe = {idx_q, cnt_q[2:0]};
  assign cap_last = vld_pipe[READ_LAT] && ({1'b0, idx_pipe[READ_LAT]} == n_q - 4'd1);
  assign done     = cap_last || done_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE_HDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_HDR: begin
        cnt_d = '0;
        if (accept && !bad) state_d = bus.req_write ? WDATA : RSLOT;
        else                state_d = IDLE_BODY;
      end
      IDLE_BODY: begin
        if (cnt_q == FILL_N) state_d = IDLE_HDR;
        else                 cnt_d   = cnt_q + 4'd1;
      end
      WDATA, RSLOT: begin
        if (cnt_q == n_q - 4'd1) state_d = TAIL;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      TAIL: begin
        cnt_d = '0;
        if (wr_q)          state_d = COMMIT;
        else if (cap_last) state_d = RESP;
        else               state_d = DRAIN;
      end
      COMMIT: state_d = RESP;
      DRAIN: begin
        // Leave only at a frame boundary so RESP lands on a header slot.
        if (cnt_q == FILL_N + 4'd1) begin
          cnt_d = '0;
          if (done) state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE_BODY;
      end
      default: state_d = IDLE_HDR;
    endcase
  end

  always_comb begin
    bus.instr     = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = err_pend_q;
    bus.busy      = err_pend_q;
    case (state_q)
      IDLE_HDR: begin
        bus.req_ready = reset_n;
        bus.busy      = accept;
        bus.instr     = (accept && !bad) ? {bus.req_write, bus.req_addr, 27'b0} : FILL_HDR;
      end
      WDATA: begin
        bus.busy  = 1'b1;
        bus.instr = wdata_q[cnt_q[2:0]];
      end
      RSLOT, TAIL, COMMIT: bus.busy = 1'b1;
      DRAIN: begin
        bus.busy  = 1'b1;
        bus.instr = (cnt_q == 4'd0) ? FILL_HDR : 32'h0;
      end
      RESP: begin
        bus.busy      = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.instr     = FILL_HDR;
      end
      default: ;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
`ifdef HOST_BRIDGE_ADDR_CHECK_EN
  assign bus.rsp_err = err_pend_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      n_q        <= 4'd1;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= '0;
      idx_q      <= '0;
    end else begin
      err_pend_q <= accept && bad;
      vld_q      <= vld_pipe[READ_LAT-1:0];
      idx_q      <= idx_pipe[READ_LAT-1:0];
      if (accept) begin
        wr_q    <= bus.req_write;
        n_q     <= nwords(bus.req_addr);
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        done_q  <= 1'b0;
      end else if (cap_last) begin
        done_q  <= 1'b1;
      end
      if (vld_pipe[READ_LAT]) rdata_q[idx_pipe[READ_LAT]] <= bus.coproc_out;
    end
  end

endmodule

// File: tb/tb_coproc_host_bridge.sv
// Bench for coproc_host_bridge: frame-tracking slave model plus a response scoreboard.
module tb_coproc_host_bridge;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  coproc_host_bridge_if bus();

  coproc_host_bridge dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] rdata;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic int tb_n(input logic [3:0] a);
    if (a inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9}) return 4;
    if (a inside {4'd5, 4'd6}) return 8;
    if (a inside {4'd12, 4'd13, 4'd14}) return 5;
    return 1;
  endfunction

  function automatic logic [255:0] rd_words(input int n);
    logic [255:0] r = '0;
    for (int k = 0; k < n; k++) r[32*k +: 32] = 32'hA5A5_0000 | 32'(k);
    return r;
  endfunction

  function automatic logic [255:0] wr_words(input logic [31:0] base);
    logic [255:0] r = '0;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = base | 32'(k);
    return r;
  endfunction

  // Slave model: follows frames from headers, checks zero slots, answers reads.
  typedef enum {M_HDR, M_WR, M_RD, M_TAIL, M_COMMIT} mmode_e;
  mmode_e     mmode;
  int         mcnt, mn;
  logic       mw;
  logic [3:0] ma;

  always @(posedge clock) begin
    if (!reset_n) begin
      mmode <= M_HDR;
      bus.coproc_out <= 32'h0;
    end else begin
      bus.coproc_out <= 32'h0;
      case (mmode)
        M_HDR: begin
          total++;
          if (bus.instr[26:0] !== 27'h0) begin
            bad++;
            $display("FAIL frame_hdr got=%h exp=low27 zero", bus.instr);
          end
          mw    <= bus.instr[31];
          ma    <= bus.instr[30:27];
          mn    <= tb_n(bus.instr[30:27]);
          mcnt  <= 0;
          mmode <= bus.instr[31] ? M_WR : M_RD;
        end
        M_WR: begin
          mcnt <= mcnt + 1;
          if (mcnt == mn - 1) mmode <= M_TAIL;
        end
        M_RD: begin
          total++;
          if (bus.instr !== 32'h0) begin
            bad++;
            $display("FAIL frame_rslot got=%h exp=0", bus.instr);
          end
          bus.coproc_out <= (ma == 4'hF) ? 32'hFFFF_FFFF : (32'hA5A5_0000 | 32'(mcnt));
          mcnt <= mcnt + 1;
          if (mcnt == mn - 1) mmode <= M_TAIL;
        end
        M_TAIL, M_COMMIT: begin
          total++;
          if (bus.instr !== 32'h0) begin
            bad++;
            $display("FAIL frame_tail got=%h exp=0", bus.instr);
          end
          mmode <= (mmode == M_TAIL && mw) ? M_COMMIT : M_HDR;
        end
        default: mmode <= M_HDR;
      endcase
    end
  end

  // Response monitor
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp got=rsp_valid exp=none at cyc %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rsp_rdata !== mon_e.rdata || bus.rsp_err !== mon_e.err ||
            (cyc - mon_e.acc) !== mon_e.lat || bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL rsp got=%h err=%b lat=%0d busy=%b exp=%h err=%b lat=%0d busy=1",
                   bus.rsp_rdata, bus.rsp_err, cyc - mon_e.acc, bus.busy,
                   mon_e.rdata, mon_e.err, mon_e.lat);
        end
      end
    end
  end

  task automatic do_req(input bit w, input logic [3:0] a, input logic [255:0] wd,
                        input bit expect_rsp, input logic [255:0] er, input bit ee,
                        input int lat, input logic [31:0] exp_hdr, input bit keep,
                        output int acc);
    bit got = 0;
    exp_t e;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (bus.req_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL accept_timeout got=no ready exp=ready within 64 cycles");
    end else begin
      acc = cyc;
      if (bus.instr !== exp_hdr || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL accept_hdr got=%h busy=%b exp=%h busy=1", bus.instr, bus.busy, exp_hdr);
      end
      if (expect_rsp) begin
        e.rdata = er; e.err = ee; e.lat = lat; e.acc = acc;
        exp_q.push_back(e);
      end
    end
    @(posedge clock); #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rsp_timeout got=%0d pending exp=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if (bus.instr !== 32'h7800_0000 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_err !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_rdata !== 256'h0) begin
      bad++;
      $display("FAIL reset_state got=instr %h rdy %b vld %b err %b busy %b exp=78000000 0 0 0 0",
               bus.instr, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      total++;
      if (bus.instr !== ((i % 3 == 0) ? 32'h7800_0000 : 32'h0) ||
          bus.req_ready !== (i % 3 == 0)) begin
        bad++;
        $display("FAIL idle_frame[%0d] got=%h rdy=%b exp=%h rdy=%b", i, bus.instr,
                 bus.req_ready, (i % 3 == 0) ? 32'h7800_0000 : 32'h0, i % 3 == 0);
      end
    end
  endtask

  task automatic test_write();
    int acc;
    logic [31:0] ew;
    do_req(1'b1, 4'd5, wr_words(32'h1000_0000), 1'b1, 256'h0, 1'b0, 11, 32'hA800_0000, 1'b0, acc);
    for (int k = 0; k < 10; k++) begin
      ew = (k < 8) ? (32'h1000_0000 | 32'(k)) : 32'h0;
      if (k > 0) @(posedge clock);
      @(negedge clock);
      total++;
      if (bus.instr !== ew) begin
        bad++;
        $display("FAIL write_slot[%0d] got=%h exp=%h", k, bus.instr, ew);
      end
    end
    wait_rsp();
  endtask

  task automatic test_read();
    int acc;
    do_req(1'b0, 4'd12, 256'h0, 1'b1, rd_words(5), 1'b0, 7, 32'h6000_0000, 1'b0, acc);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(posedge clock);
      @(negedge clock);
      total++;
      if (bus.instr !== 32'h0) begin
        bad++;
        $display("FAIL read_slot[%0d] got=%h exp=0", k, bus.instr);
      end
    end
    wait_rsp();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    do_req(1'b1, 4'd0, wr_words(32'h2000_0000), 1'b1, 256'h0, 1'b0, 7, 32'h8000_0000, 1'b1, acc1);
    do_req(1'b0, 4'd6, 256'h0, 1'b1, rd_words(8), 1'b0, 10, 32'h3000_0000, 1'b0, acc2);
    total++;
    if (acc2 - acc1 !== 10) begin
      bad++;
      $display("FAIL b2b_accept got=%0d exp=10 cycles between accepts", acc2 - acc1);
    end
    wait_rsp();
  endtask

  task automatic test_reset_mid();
    int acc;
    do_req(1'b1, 4'd5, wr_words(32'h3000_0000), 1'b0, 256'h0, 1'b0, 0, 32'hA800_0000, 1'b0, acc);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (bus.instr !== 32'h7800_0000 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got=%h vld=%b busy=%b exp=78000000 0 0",
               bus.instr, bus.rsp_valid, bus.busy);
    end
    repeat (20) @(posedge clock);
    do_req(1'b0, 4'd12, 256'h0, 1'b1, rd_words(5), 1'b0, 7, 32'h6000_0000, 1'b0, acc);
    wait_rsp();
  endtask

  task automatic test_addr_check();
    int acc;
`ifdef HOST_BRIDGE_ADDR_CHECK_EN
    do_req(1'b0, 4'd3, 256'h0, 1'b1, 256'h0, 1'b1, 1, 32'h7800_0000, 1'b0, acc);
`else
    do_req(1'b0, 4'd3, 256'h0, 1'b1, rd_words(1), 1'b0, 3, 32'h1800_0000, 1'b0, acc);
`endif
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(posedge clock);
      @(negedge clock);
      total++;
      if (bus.instr !== 32'h0) begin
        bad++;
        $display("FAIL addr_check_body[%0d] got=%h exp=0", k, bus.instr);
      end
    end
    wait_rsp();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 4'h0;
    bus.req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_addr_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
